// File: rtl/hb_interp.sv
// Half-band interpolate-by-2 filter: each accepted sample produces an even-branch
// output (A) followed by a centre-tap output (B) on a valid/ready stream.
module hb_interp (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] y_out,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {StIdle, StCalc, StOutA, StOutB} state_e;

  localparam logic signed [15:0] W13 = 16'sd16383;

  state_e             state_q, state_d;
  logic signed [15:0] dly_q [14];
  logic        [15:0] y_q, y_d;
  logic               out_valid_q, out_valid_d;
  logic               accept;

  logic signed [16:0] pre;
  logic signed [32:0] prod;
  logic signed [35:0] acc_a;
  logic signed [35:0] acc_b;

  // Even-branch coefficient for the symmetric pair (d[k], d[13-k]).
  function automatic logic signed [15:0] coef(input int k);
    case (k)
      0:       coef = 16'sd459;
      1:       coef = -16'sd484;
      2:       coef = 16'sd749;
      3:       coef = -16'sd1154;
      4:       coef = 16'sd1834;
      5:       coef = -16'sd3323;
      default: coef = 16'sd10377;
    endcase
  endfunction

  // Floor shift by 14 then clamp to the signed 16-bit range.
  function automatic logic [15:0] sat16(input logic signed [35:0] v);
    logic signed [35:0] s;
    s = v >>> 14;
    if (s > 36'sd32767) begin
      sat16 = 16'h7fff;
    end else if (s < -36'sd32768) begin
      sat16 = 16'h8000;
    end else begin
      sat16 = s[15:0];
    end
  endfunction

  always_comb begin
    acc_a = '0;
    pre   = '0;
    prod  = '0;
    for (int k = 0; k < 7; k++) begin
      pre   = 17'(dly_q[k]) + 17'(dly_q[13-k]);
      prod  = 33'(pre) * 33'(coef(k));
      acc_a = acc_a + 36'(prod);
    end
    acc_b = 36'(dly_q[6]) * 36'(W13);
  end

  assign in_ready  = (state_q == StIdle);
  assign accept    = in_valid && in_ready;
  assign y_out     = y_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) state_d = StCalc;
      end
      StCalc: begin
        y_d         = sat16(acc_a);
        out_valid_d = 1'b1;
        state_d     = StOutA;
      end
      StOutA: begin
        if (out_ready) begin
          y_d     = sat16(acc_b);
          state_d = StOutB;
        end
      end
      StOutB: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < 14; k++) dly_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        dly_q[0] <= $signed(x_in);
        for (int k = 1; k < 14; k++) dly_q[k] <= dly_q[k-1];
      end
    end
  end

endmodule
